// File: rtl/net_pkg.sv
// Shared definitions for the network sequencer and network manager: state encoding
// and the register address map of the neural-network register file.
package net_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    COMMIT_W,
    LOAD_I,
    COMMIT_I,
    WAIT_RDY,
    READ_O,
    HOLD_O
  } state_t;

  function automatic int weight_count(input int li, input int mid, input int lo);
    return li * mid + mid * lo;
  endfunction

  function automatic int commit_w_addr(input int li, input int mid, input int lo);
    return weight_count(li, mid, lo);
  endfunction

  function automatic int input_base(input int li, input int mid, input int lo);
    return weight_count(li, mid, lo) + 1;
  endfunction

  function automatic int commit_i_addr(input int li, input int mid, input int lo);
    return weight_count(li, mid, lo) + li + 1;
  endfunction

  function automatic int output_base(input int li, input int mid, input int lo);
    return weight_count(li, mid, lo) + li + 2;
  endfunction

endpackage

// File: rtl/net_sequencer.sv
// Streams weights and inputs into the network register file, waits for the result
// and streams the output neurons back out with a valid/ready handshake.
module net_sequencer
  import net_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LENGHT_I   = 2,
  parameter int LENGHT_MID = 2,
  parameter int LENGHT_O   = 2,
  parameter int TIMEOUT    = 64,
  parameter int WIDTH_ADDR = $clog2(LENGHT_I*LENGHT_MID + LENGHT_MID*LENGHT_O + LENGHT_I + LENGHT_O + 3)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_w,
  input  logic                  run,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH-1:0]      s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  err,
  output logic [WIDTH_ADDR-1:0] address,
  output logic                  write,
  output logic                  read,
  output logic [WIDTH-1:0]      in_d,
  input  logic [WIDTH-1:0]      out_d,
  input  logic                  net_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [WIDTH_ADDR-1:0] A_COMMIT_W = WIDTH_ADDR'(commit_w_addr(LENGHT_I, LENGHT_MID, LENGHT_O));
  localparam logic [WIDTH_ADDR-1:0] A_IN_BASE  = WIDTH_ADDR'(input_base(LENGHT_I, LENGHT_MID, LENGHT_O));
  localparam logic [WIDTH_ADDR-1:0] A_COMMIT_I = WIDTH_ADDR'(commit_i_addr(LENGHT_I, LENGHT_MID, LENGHT_O));
  localparam logic [WIDTH_ADDR-1:0] A_OUT_BASE = WIDTH_ADDR'(output_base(LENGHT_I, LENGHT_MID, LENGHT_O));

  localparam logic [WIDTH_ADDR-1:0] LAST_W    = WIDTH_ADDR'(weight_count(LENGHT_I, LENGHT_MID, LENGHT_O) - 1);
  localparam logic [WIDTH_ADDR-1:0] LAST_I    = WIDTH_ADDR'(LENGHT_I - 1);
  localparam logic [WIDTH_ADDR-1:0] LAST_O    = WIDTH_ADDR'(LENGHT_O - 1);
  localparam logic [CNT_W-1:0]      LAST_WAIT = CNT_W'(TIMEOUT - 1);

  state_t                state_reg, state_next;
  logic [WIDTH_ADDR-1:0] idx_reg, idx_next;
  logic [CNT_W-1:0]      wait_reg, wait_next;
  logic                  w_loaded_reg, w_loaded_next;
  logic                  captured_reg, captured_next;
  logic [WIDTH-1:0]      m_data_reg, m_data_next;
  logic                  err_reg, err_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      wait_reg     <= '0;
      w_loaded_reg <= 1'b0;
      captured_reg <= 1'b0;
      m_data_reg   <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      wait_reg     <= wait_next;
      w_loaded_reg <= w_loaded_next;
      captured_reg <= captured_next;
      m_data_reg   <= m_data_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    wait_next     = wait_reg;
    w_loaded_next = w_loaded_reg;
    captured_next = captured_reg;
    m_data_next   = m_data_reg;
    err_next      = 1'b0;
    s_ready       = 1'b0;
    write         = 1'b0;
    read          = 1'b0;
    in_d          = '0;
    address       = '0;
    m_valid       = 1'b0;
    m_last        = 1'b0;

    case (state_reg)
      IDLE: begin
        // load_w has priority; a simultaneous run is simply dropped
        if (load_w) begin
          state_next = LOAD_W;
          idx_next   = '0;
        end else if (run) begin
          if (w_loaded_reg) begin
            state_next = LOAD_I;
            idx_next   = '0;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      LOAD_W: begin
        s_ready = 1'b1;
        if (s_valid) begin
          write   = 1'b1;
          in_d    = s_data;
          address = idx_reg;
          if (idx_reg == LAST_W) begin
            state_next = COMMIT_W;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      COMMIT_W: begin
        write         = 1'b1;
        in_d          = '1;
        address       = A_COMMIT_W;
        w_loaded_next = 1'b1;
        state_next    = IDLE;
      end
      LOAD_I: begin
        s_ready = 1'b1;
        if (s_valid) begin
          write   = 1'b1;
          in_d    = s_data;
          address = A_IN_BASE + idx_reg;
          if (idx_reg == LAST_I) begin
            state_next = COMMIT_I;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      COMMIT_I: begin
        write      = 1'b1;
        in_d       = '1;
        address    = A_COMMIT_I;
        wait_next  = '0;
        state_next = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (net_ready) begin
          state_next = READ_O;
          idx_next   = '0;
        end else if (wait_reg == LAST_WAIT) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      READ_O: begin
        read          = 1'b1;
        address       = A_OUT_BASE + idx_reg;
        captured_next = 1'b0;
        state_next    = HOLD_O;
      end
      HOLD_O: begin
        // out_d is only valid in the first cycle after the read strobe
        if (!captured_reg) begin
          m_data_next   = out_d;
          captured_next = 1'b1;
        end else begin
          m_valid = 1'b1;
          m_last  = (idx_reg == LAST_O);
          if (m_ready) begin
            if (idx_reg == LAST_O) begin
              state_next = IDLE;
              idx_next   = '0;
            end else begin
              state_next = READ_O;
              idx_next   = idx_reg + 1'b1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy   = (state_reg != IDLE);
  assign err    = err_reg;
  assign m_data = m_data_reg;

endmodule
